// File: rtl/instr_fetch_queue.sv
// Purpose : prefetches 16-bit instructions from a synchronous instruction memory into a FWFT queue for dispatch.
// Latency : read issued in cycle N returns in N+1 and is at the queue head (Valid) in N+2.
// Backpressure: reads are issued only while queued + in-flight entries leave room, so Pop alone throttles fetch.
//
// Ports:
//   Clock, Reset          rising-edge clock, asynchronous active-high reset
//   Pop                   dispatch consumes the head instruction (ignored when Valid=0)
//   Flush, Flush_pc       drop the queue and any in-flight read, restart fetch at Flush_pc
//   Mem_rd, Mem_addr      registered read request / address to instruction memory
//   Mem_data              read data, valid the cycle after Mem_rd
//   Instr_out, Instr_pc   head instruction and its address (zero when Valid=0)
//   Valid, Full, Done     queue non-empty / queue full / program fetched and drained
module instr_fetch_queue #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 8,
  parameter int PROG_LEN = 7
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Pop,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] Flush_pc,
  output logic              Mem_rd,
  output logic [ADDR_W-1:0] Mem_addr,
  input  logic [15:0]       Mem_data,
  output logic [15:0]       Instr_out,
  output logic [ADDR_W-1:0] Instr_pc,
  output logic              Valid,
  output logic              Full,
  output logic              Done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // fetched must be able to hold PROG_LEN == 2^ADDR_W
  localparam int FCH_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_STOP  = 2'd2;

  localparam logic [FCH_W-1:0] PROG_LEN_C = FCH_W'(PROG_LEN);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   CREDIT_C   = (CNT_W+1)'(DEPTH);

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [FCH_W-1:0]  fetched, fetched_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              inflight, inflight_nxt;
  logic [ADDR_W-1:0] inflight_pc;
  logic              mem_rd_q, mem_rd_nxt;
  logic              do_write, do_pop;

  logic [15:0]       q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];

  // Flush wins over both the returning write and a Pop in the same cycle.
  assign do_write = inflight & ~Flush;
  assign do_pop   = Pop & Valid & ~Flush;

  always_comb begin
    count_nxt    = count;
    inflight_nxt = 1'b0;
    fetched_nxt  = fetched;
    pc_nxt       = pc;
    state_nxt    = state;
    mem_rd_nxt   = 1'b0;

    if (Flush) begin
      count_nxt    = '0;
      inflight_nxt = 1'b0;
      fetched_nxt  = '0;
      pc_nxt       = Flush_pc;
      state_nxt    = S_FETCH;
    end else begin
      count_nxt    = count + CNT_W'(do_write) - CNT_W'(do_pop);
      inflight_nxt = mem_rd_q;
      fetched_nxt  = fetched + FCH_W'(mem_rd_q);
      pc_nxt       = pc + ADDR_W'(mem_rd_q);
      case (state)
        S_IDLE:  state_nxt = S_FETCH;
        S_FETCH: state_nxt = (fetched_nxt == PROG_LEN_C) ? S_STOP : S_FETCH;
        default: state_nxt = S_STOP;
      endcase
    end

    // Decide next cycle's read from post-edge occupancy: queued entries plus
    // the read that will be in flight must leave room for one more.
    if (state_nxt == S_FETCH && fetched_nxt < PROG_LEN_C &&
        ({1'b0, count_nxt} + (CNT_W+1)'(inflight_nxt)) < CREDIT_C)
      mem_rd_nxt = 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      fetched     <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      mem_rd_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetched     <= fetched_nxt;
      count       <= count_nxt;
      inflight    <= inflight_nxt;
      inflight_pc <= pc;
      mem_rd_q    <= mem_rd_nxt;
      if (Flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage is not reset; Valid gates everything read out of it.
  always_ff @(posedge Clock) begin
    if (do_write) begin
      q_instr[wr_ptr] <= Mem_data;
      q_pc[wr_ptr]    <= inflight_pc;
    end
  end

  // pc is the address of the read presented this cycle, so it doubles as Mem_addr.
  assign Mem_rd    = mem_rd_q;
  assign Mem_addr  = pc;
  assign Valid     = (count != '0);
  assign Full      = (count == DEPTH_C);
  assign Done      = (state == S_STOP) && (count == '0) && !inflight;
  assign Instr_out = Valid ? q_instr[rd_ptr] : 16'h0000;
  assign Instr_pc  = Valid ? q_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Purpose : directed bench for instr_fetch_queue (PROG_LEN=7 and PROG_LEN=12 instances side by side).
// Latency : instruction memory model answers one cycle after Mem_rd.
// Backpressure: Pop driven directly per phase.
module tb_instr_fetch_queue;

  logic        Clock;
  logic        Reset;

  logic        pop_a, flush_a, mem_rd_a, valid_a, full_a, done_a;
  logic [7:0]  flush_pc_a, mem_addr_a, instr_pc_a;
  logic [15:0] mem_data_a, instr_out_a;

  logic        pop_b, flush_b, mem_rd_b, valid_b, full_b, done_b;
  logic [7:0]  flush_pc_b, mem_addr_b, instr_pc_b;
  logic [15:0] mem_data_b, instr_out_b;

  logic [15:0] imem [256];
  logic [15:0] prog [7];

  int total;
  int bad;

  instr_fetch_queue #(.DEPTH(8), .ADDR_W(8), .PROG_LEN(7)) dut_a (
    .Clock(Clock), .Reset(Reset), .Pop(pop_a), .Flush(flush_a), .Flush_pc(flush_pc_a),
    .Mem_rd(mem_rd_a), .Mem_addr(mem_addr_a), .Mem_data(mem_data_a),
    .Instr_out(instr_out_a), .Instr_pc(instr_pc_a),
    .Valid(valid_a), .Full(full_a), .Done(done_a)
  );

  instr_fetch_queue #(.DEPTH(8), .ADDR_W(8), .PROG_LEN(12)) dut_b (
    .Clock(Clock), .Reset(Reset), .Pop(pop_b), .Flush(flush_b), .Flush_pc(flush_pc_b),
    .Mem_rd(mem_rd_b), .Mem_addr(mem_addr_b), .Mem_data(mem_data_b),
    .Instr_out(instr_out_b), .Instr_pc(instr_pc_b),
    .Valid(valid_b), .Full(full_b), .Done(done_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // synchronous instruction memories, one cycle read latency
  always @(posedge Clock) begin
    if (mem_rd_a) mem_data_a <= imem[mem_addr_a];
    if (mem_rd_b) mem_data_b <= imem[mem_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  // leaves the bench 1 time unit after an edge with Reset just released
  task automatic do_reset;
    Reset   = 1'b1;
    pop_a   = 1'b0;
    pop_b   = 1'b0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total      = 0;
    bad        = 0;
    flush_pc_a = 8'd0;
    flush_pc_b = 8'd0;
    mem_data_a = 16'h0000;
    mem_data_b = 16'h0000;
    prog[0] = 16'h1012; prog[1] = 16'h2012; prog[2] = 16'h1012; prog[3] = 16'h1012;
    prog[4] = 16'h1012; prog[5] = 16'h1012; prog[6] = 16'h2012;
    for (int i = 0; i < 256; i++) imem[i] = 16'h3000 | 16'(i);
    for (int i = 0; i < 7; i++) imem[i] = prog[i];

    // ---- phase 1: A fills with 7, B fills to Full; B pops while empty ----
    Reset   = 1'b1;
    pop_a   = 1'b0;
    pop_b   = 1'b0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    step();
    step();
    chk("rst_rd",    32'(mem_rd_a),    32'd0);
    chk("rst_addr",  32'(mem_addr_a),  32'd0);
    chk("rst_valid", 32'(valid_a),     32'd0);
    chk("rst_full",  32'(full_a),      32'd0);
    chk("rst_done",  32'(done_a),      32'd0);
    chk("rst_instr", 32'(instr_out_a), 32'd0);
    chk("rst_pc",    32'(instr_pc_a),  32'd0);
    Reset = 1'b0;
    pop_b = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 2) pop_b = 1'b0;
      chk("a_rd", 32'(mem_rd_a), 32'(k <= 7));
      if (k <= 7) chk("a_addr", 32'(mem_addr_a), 32'(k - 1));
      chk("b_rd", 32'(mem_rd_b), 32'(k <= 8));
      if (k <= 8) chk("b_addr", 32'(mem_addr_b), 32'(k - 1));
      if (k <= 2) begin
        chk("b_pop_empty_valid", 32'(valid_b), 32'd0);
        chk("b_pop_empty_pc", 32'(instr_pc_b), 32'd0);
      end
    end
    chk("a_fill_valid", 32'(valid_a),     32'd1);
    chk("a_fill_full",  32'(full_a),      32'd0);
    chk("a_fill_done",  32'(done_a),      32'd0);
    chk("a_fill_instr", 32'(instr_out_a), 32'h1012);
    chk("a_fill_pc",    32'(instr_pc_a),  32'd0);
    chk("b_full",       32'(full_b),      32'd1);
    chk("b_done",       32'(done_b),      32'd0);
    chk("b_head_pc",    32'(instr_pc_b),  32'd0);
    chk("b_head_instr", 32'(instr_out_b), 32'h1012);
    // single pop on a full queue releases exactly one read
    pop_b = 1'b1;
    step();
    pop_b = 1'b0;
    chk("b_pop_rd",    32'(mem_rd_b),    32'd1);
    chk("b_pop_addr",  32'(mem_addr_b),  32'd8);
    chk("b_pop_full",  32'(full_b),      32'd0);
    chk("b_pop_pc",    32'(instr_pc_b),  32'd1);
    chk("b_pop_instr", 32'(instr_out_b), 32'h2012);
    step();
    chk("b_pop1_rd",   32'(mem_rd_b),    32'd0);
    chk("b_pop1_full", 32'(full_b),      32'd0);
    step();
    chk("b_pop2_rd",   32'(mem_rd_b),    32'd0);
    chk("b_pop2_full", 32'(full_b),      32'd1);

    // ---- phase 2: Pop held high from release, stream whole program ----
    do_reset();
    pop_a = 1'b1;
    step();
    step();
    chk("stream_pre_valid", 32'(valid_a), 32'd0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("stream_valid", 32'(valid_a),     32'd1);
      chk("stream_pc",    32'(instr_pc_a),  32'(i));
      chk("stream_instr", 32'(instr_out_a), 32'(prog[i]));
      chk("stream_done",  32'(done_a),      32'd0);
    end
    step();
    pop_a = 1'b0;
    chk("stream_end_valid", 32'(valid_a), 32'd0);
    chk("stream_end_done",  32'(done_a),  32'd1);

    // ---- phase 3: flush to 3 with 4 queued and one read in flight ----
    do_reset();
    for (int k = 1; k <= 6; k++) step();
    chk("pre_flush_valid", 32'(valid_a),    32'd1);
    chk("pre_flush_rd",    32'(mem_rd_a),   32'd1);
    chk("pre_flush_addr",  32'(mem_addr_a), 32'd5);
    flush_a    = 1'b1;
    flush_pc_a = 8'd3;
    step();
    flush_a = 1'b0;
    chk("flush_valid", 32'(valid_a),    32'd0);
    chk("flush_rd",    32'(mem_rd_a),   32'd1);
    chk("flush_addr",  32'(mem_addr_a), 32'd3);
    chk("flush_done",  32'(done_a),     32'd0);
    step();
    chk("flush1_valid", 32'(valid_a),    32'd0);
    chk("flush1_addr",  32'(mem_addr_a), 32'd4);
    step();
    chk("flush2_valid", 32'(valid_a),     32'd1);
    chk("flush2_pc",    32'(instr_pc_a),  32'd3);
    chk("flush2_instr", 32'(instr_out_a), 32'h1012);
    step();
    chk("flush3_pc",    32'(instr_pc_a),  32'd3);

    // ---- phase 4: async reset between edges with 5 queued ----
    do_reset();
    for (int k = 1; k <= 7; k++) step();
    chk("pre_arst_valid", 32'(valid_a),    32'd1);
    chk("pre_arst_rd",    32'(mem_rd_a),   32'd1);
    chk("pre_arst_addr",  32'(mem_addr_a), 32'd6);
    #3;
    Reset = 1'b1;
    #1;
    chk("arst_rd",    32'(mem_rd_a),    32'd0);
    chk("arst_addr",  32'(mem_addr_a),  32'd0);
    chk("arst_valid", 32'(valid_a),     32'd0);
    chk("arst_full",  32'(full_a),      32'd0);
    chk("arst_done",  32'(done_a),      32'd0);
    chk("arst_instr", 32'(instr_out_a), 32'd0);
    chk("arst_pc",    32'(instr_pc_a),  32'd0);
    step();
    Reset = 1'b0;
    step();
    chk("rerun_rd",   32'(mem_rd_a),   32'd1);
    chk("rerun_addr", 32'(mem_addr_a), 32'd0);
    step();
    chk("rerun_valid0", 32'(valid_a), 32'd0);
    step();
    chk("rerun_valid1", 32'(valid_a),     32'd1);
    chk("rerun_pc",     32'(instr_pc_a),  32'd0);
    chk("rerun_instr",  32'(instr_out_a), 32'h1012);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction-supply end of the dispatch handshake: the tomasulo core asserts Pop to consume instructions, and this block supplies them.
- Prefetches 16-bit instructions from a synchronous instruction memory into a first-word-fall-through FIFO.
- Head instruction is always presented to the dispatch unit; Pop retires it.
- Sits between instruction memory and the dispatch unit inside tomasulo.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=2)
ADDR_W, 8, instruction memory address width
PROG_LEN, 7, number of instructions fetched after reset before fetch stops (1..2^ADDR_W)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Pop  in  1  dispatch consumes head instruction this cycle
Flush  in  1  synchronous: discard queue and restart fetch at Flush_pc
Flush_pc  in  ADDR_W  restart address, valid with Flush
Mem_rd  out  1  read request to instruction memory
Mem_addr  out  ADDR_W  read address
Mem_data  in  16  read data, valid exactly 1 cycle after Mem_rd
Instr_out  out  16  head instruction ([15:12] opcode, [11:8] Rd, [7:4] Rs, [3:0] Rt)
Instr_pc  out  ADDR_W  address of head instruction
Valid  out  1  queue non-empty; Instr_out is meaningful
Full  out  1  count == DEPTH
Done  out  1  all PROG_LEN instructions fetched and queue drained

Behaviour:
- Reset (async, active-high) clears these immediately, without waiting for a clock edge: pc=0, fetched=0, count=0, rd/wr ptrs=0, inflight=0, Mem_rd=0, Mem_addr=0, Valid=0, Full=0, Done=0, Instr_out=0, Instr_pc=0.
- Reset asserted mid-operation discards all entries and any in-flight read; data returning the cycle after release is ignored.
- Fetch FSM states:
  - IDLE: one cycle after reset release, then go to FETCH.
  - FETCH: issue reads while count+inflight < DEPTH.
  - STOP: reached when fetched == PROG_LEN.
- Fetch rule: in a cycle with Mem_rd=1, pc and fetched both increment. inflight is 1 in the cycle after a read is issued. At most one read is issued per cycle, so reads can be back-to-back at 1 instruction/cycle.
- Write: when inflight=1, Mem_data and its pc are written at wr_ptr at the next rising edge.
- Credit check: because the credit check counts inflight, a write can never overflow the queue.
- Read side:
  - Instr_out and Instr_pc are taken combinationally from the rd_ptr entry (FWFT).
  - Valid = (count != 0).
  - Pop with Valid=1 advances rd_ptr at the rising edge.
  - Pop with Valid=0 is ignored: no state change and no underflow.
- Simultaneous write and Pop: count is unchanged; both pointers advance.
- Pop on a count=1 entry in the same cycle as a write leaves Valid=1, with the new entry at the head next cycle.
- Pointers wrap modulo DEPTH. count has width log2(DEPTH)+1. pc wraps modulo 2^ADDR_W.
- Flush has priority over Pop and over writes:
  - Next edge: count=0, pointers=0, pc=Flush_pc, fetched=0, inflight data discarded, FSM -> FETCH.
  - The first read at Flush_pc issues the cycle after the flush edge.
- Full = (count == DEPTH). Full blocks Mem_rd.
- Done = 1 when the FSM is in STOP, count=0 and inflight=0. Done is cleared by Reset or Flush.
- Output timing: Mem_rd and Mem_addr are registered. Valid, Full and Done are derived from registered state with no combinational path from Pop.

Test Plan:
- Reset, then release with Pop=0, memory holding 7 instructions (ADD/SUB R0,R1,R2 pattern: 16'h1012, 16'h2012 ...) -> Mem_rd issued for addresses 0..6 on consecutive cycles; count reaches 7; Valid=1; Full=0; FSM reaches STOP.
- PROG_LEN=12, DEPTH=8, Pop=0 -> exactly 8 reads; Full=1; Mem_rd stays 0. Then Pop for one cycle -> exactly one new read; Full=1 again 2 cycles later.
- Pop held high from reset release (PROG_LEN=7) -> Instr_out sequence is 1012,2012,1012,1012,1012,1012,2012 with Instr_pc 0..6, one per cycle; no duplicates; Done=1 after the last pop.
- Pop while Valid=0 (right after reset) -> count stays 0, rd_ptr unchanged, no spurious Instr_pc change.
- Flush with Flush_pc=3 while 4 entries are queued and one read is in flight -> next cycle Valid=0; the in-flight data is dropped; next Mem_addr=3; the first Instr_pc delivered is 3.
- Reset asserted between clock edges while count=5 -> all outputs return to 0 immediately, before the next rising edge; fetch restarts at address 0 after release.
